// File: rtl/toy_bus_arb_pkg.sv
// toy_bus_arb_pkg: shared constants, lock states and helpers
// for the oldest-first bus arbiter.
package toy_bus_arb_pkg;

  localparam int ARB_MAX_IN = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_st_e;

  function automatic logic [3:0] onehot2idx(
    input logic [ARB_MAX_IN-1:0] oh
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < ARB_MAX_IN; i++)
      if (oh[i]) r |= 4'(i);
    return r;
  endfunction

  // reset age pattern: lower index is older
  function automatic logic age_rst(input int i, input int j);
    return j < i;
  endfunction

endpackage

// File: rtl/toy_bus_age_arb_lock_n_if.sv
// toy_bus_age_arb_lock_n_if: N-input request side and
// single output side of the merge-node arbiter.
interface toy_bus_age_arb_lock_n_if #(
  parameter int N_IN  = 4,
  parameter int PLD_W = 330
);
  localparam int ID_W = $clog2(N_IN);

  logic [N_IN-1:0]       in_vld;
  logic [N_IN-1:0]       in_rdy;
  logic [N_IN-1:0]       in_last;
  logic [N_IN*PLD_W-1:0] in_pld;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  out_last;
  logic [PLD_W-1:0]      out_pld;
  logic [ID_W-1:0]       out_gnt_id;
  logic                  lock_busy;

  modport slave (
    input  in_vld, in_last, in_pld, out_rdy,
    output in_rdy, out_vld, out_last, out_pld,
    output out_gnt_id, lock_busy
  );

  modport master (
    output in_vld, in_last, in_pld, out_rdy,
    input  in_rdy, out_vld, out_last, out_pld,
    input  out_gnt_id, lock_busy
  );

endinterface

// File: rtl/toy_bus_age_mtx_n.sv
// toy_bus_age_mtx_n: age matrix, one flop per input pair
// (upper triangle), lower triangle is its complement.
module toy_bus_age_mtx_n
  import toy_bus_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   update_en,
  output logic [N*N-1:0] age
);

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      if (i < j) begin : g_ff
        logic q;
        // q=1: j older than i; updated input becomes youngest
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n)            q <= age_rst(i, j);
          else if (update_en[i]) q <= 1'b1;
          else if (update_en[j]) q <= 1'b0;
        assign age[i*N+j] = q;
        assign age[j*N+i] = ~q;
      end else if (i == j) begin : g_d
        assign age[i*N+i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/toy_bus_age_arb_lock_n.sv
// toy_bus_age_arb_lock_n: oldest-first arbiter with burst lock.
// TOY_BUS_AGE_ARB_OUT_REG_EN adds a one-entry output slice.
module toy_bus_age_arb_lock_n
  import toy_bus_arb_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int PLD_W = 330
) (
  input logic clk,
  input logic rst_n,
  toy_bus_age_arb_lock_n_if.slave bus
);

  localparam int ID_W = $clog2(N_IN);

  logic [N_IN*N_IN-1:0] age;
  logic [N_IN-1:0]      vld;
  logic [N_IN-1:0]      sel;
  logic [N_IN-1:0]      lk_oh;
  logic [N_IN-1:0]      grant;
  logic [N_IN-1:0]      upd;
  logic                 acc;
  logic                 hs;
  logic                 g_last;
  logic [PLD_W-1:0]     g_pld;
  logic [ID_W-1:0]      g_id;
  logic [ID_W-1:0]      lock_id;
  arb_st_e              st;

  assign vld = bus.in_vld;

  toy_bus_age_mtx_n #(.N(N_IN)) u_mtx (
    .clk       (clk),
    .rst_n     (rst_n),
    .update_en (upd),
    .age       (age)
  );

  // pick the valid input with no older valid input
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_IN; i++)
      sel[i] = vld[i] & ~|(age[i*N_IN +: N_IN] & vld);
  end

  assign lk_oh = N_IN'(1) << lock_id;
  assign grant = (st == ARB_LOCKED) ? (lk_oh & vld) : sel;

  // AND-OR mux of the granted beat
  always_comb begin
    g_pld  = '0;
    g_last = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (grant[i]) begin
        g_pld  |= bus.in_pld[i*PLD_W +: PLD_W];
        g_last |= bus.in_last[i];
      end
  end

  assign g_id = ID_W'(onehot2idx(ARB_MAX_IN'(grant)));

  assign bus.in_rdy    = grant & {N_IN{acc}};
  assign hs            = |grant & acc;
  assign upd           = grant & bus.in_last & {N_IN{acc}};
  assign bus.lock_busy = (st == ARB_LOCKED);

  // burst lock: hold grant from first beat to last beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= ARB_IDLE;
      lock_id <= '0;
    end else begin
      unique case (st)
        ARB_IDLE:
          if (hs && !g_last) begin
            st      <= ARB_LOCKED;
            lock_id <= g_id;
          end
        ARB_LOCKED:
          if (hs && g_last) st <= ARB_IDLE;
        default: st <= ARB_IDLE;
      endcase
    end

`ifdef TOY_BUS_AGE_ARB_OUT_REG_EN
  logic             s_full;
  logic             s_last;
  logic [PLD_W-1:0] s_pld;
  logic [ID_W-1:0]  s_id;

  assign acc = ~s_full | bus.out_rdy;

  // output slice: load on accept, drain on out_rdy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_full <= 1'b0;
      s_last <= 1'b0;
      s_pld  <= '0;
      s_id   <= '0;
    end else if (hs) begin
      s_full <= 1'b1;
      s_last <= g_last;
      s_pld  <= g_pld;
      s_id   <= g_id;
    end else if (bus.out_rdy) begin
      s_full <= 1'b0;
    end

  assign bus.out_vld    = s_full;
  assign bus.out_last   = s_last;
  assign bus.out_pld    = s_pld;
  assign bus.out_gnt_id = s_id;
`else
  assign acc            = bus.out_rdy;
  assign bus.out_vld    = |grant;
  assign bus.out_last   = g_last;
  assign bus.out_pld    = g_pld;
  assign bus.out_gnt_id = g_id;
`endif

endmodule
